// File: rtl/diff_io_prbs_loopback.sv
// ============================================================================
// Module  : diff_io_prbs_loopback
// Brief   : Per-channel PRBS7 differential TX/RX loopback tester with lock FSM
//           and saturating error counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module I_BUF_DS (
  input  logic I_P,
  input  logic I_N,
  input  logic EN,
  output logic O
);
  assign O = EN & I_P & ~I_N;
endmodule

module O_BUFT_DS (
  input  logic I,
  input  logic T,
  output logic O_P,
  output logic O_N
);
  assign O_P = T ? I  : 1'bz;
  assign O_N = T ? ~I : 1'bz;
endmodule

module diff_io_prbs_loopback #(
  parameter int CHANNELS = 4,
  parameter int ERR_W    = 16,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int TX_INV   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      oe,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       inj_err,
  input  logic [CHANNELS-1:0]       din_p,
  input  logic [CHANNELS-1:0]       din_n,
  output logic [CHANNELS-1:0]       dout_p,
  output logic [CHANNELS-1:0]       dout_n,
  output logic [CHANNELS-1:0]       lock,
  output logic [CHANNELS*ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HUNT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic       c_inv       = (TX_INV != 0);
  localparam logic [7:0] c_lock_last = 8'(LOCK_CNT - 1);
  localparam logic [3:0] c_loss_last = 4'(LOSS_CNT - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [6:0] c_seed = 7'(i + 1);

    logic [6:0]       r_lfsr;
    logic             r_tx_q;
    logic             r_rx_q;
    logic [6:0]       r_rx_sr;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_fill, w_fill_nxt;
    logic [7:0]       r_good, w_good_nxt;
    logic [3:0]       r_bad, w_bad_nxt;
    logic [ERR_W-1:0] r_err;
    logic             w_e;
    logic             w_inc;
    logic             w_rx_o;

    O_BUFT_DS u_obuf (
      .I   (r_tx_q ^ c_inv),
      .T   (oe),
      .O_P (dout_p[i]),
      .O_N (dout_n[i])
    );

    I_BUF_DS u_ibuf (
      .I_P (din_p[i]),
      .I_N (din_n[i]),
      .EN  (1'b1),
      .O   (w_rx_o)
    );

    // PRBS7 x^7+x^6+1, output taken from the oldest stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lfsr <= c_seed;
        r_tx_q <= 1'b0;
      end else if (en) begin
        r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        r_tx_q <= r_lfsr[6] ^ inj_err[i];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rx_q  <= 1'b0;
        r_rx_sr <= 7'd0;
      end else begin
        r_rx_q <= w_rx_o ^ c_inv;
        if (en) r_rx_sr <= {r_rx_sr[5:0], r_rx_q};
      end
    end

    // Self-synchronising check: the recurrence holds for any phase of the sequence
    assign w_e = r_rx_q ^ r_rx_sr[5] ^ r_rx_sr[6];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_fill  <= 3'd0;
        r_good  <= 8'd0;
        r_bad   <= 4'd0;
      end else begin
        r_state <= w_state_nxt;
        r_fill  <= w_fill_nxt;
        r_good  <= w_good_nxt;
        r_bad   <= w_bad_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_inc       = 1'b0;
      if (!en) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = 3'd0;
          end
          ST_FILL: begin
            if (r_fill == 3'd6) begin
              w_state_nxt = ST_HUNT;
              w_good_nxt  = 8'd0;
            end else begin
              w_fill_nxt = r_fill + 3'd1;
            end
          end
          ST_HUNT: begin
            if (w_e) begin
              w_good_nxt = 8'd0;
            end else if (r_good == c_lock_last) begin
              w_state_nxt = ST_LOCKED;
              w_bad_nxt   = 4'd0;
            end else begin
              w_good_nxt = r_good + 8'd1;
            end
          end
          default: begin
            if (w_e) begin
              w_inc = 1'b1;
              if (r_bad == c_loss_last) begin
                w_state_nxt = ST_HUNT;
                w_good_nxt  = 8'd0;
              end else begin
                w_bad_nxt = r_bad + 4'd1;
              end
            end else begin
              w_bad_nxt = 4'd0;
            end
          end
        endcase
      end
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_err <= '0;
      end else if (clear) begin
        r_err <= '0;
      end else if (w_inc && (r_err != {ERR_W{1'b1}})) begin
        r_err <= r_err + 1'b1;
      end
    end

    assign lock[i]                  = (r_state == ST_LOCKED);
    assign err_cnt[i*ERR_W +: ERR_W] = r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_diff_io_prbs_loopback.sv
// ============================================================================
// Module  : tb_diff_io_prbs_loopback
// Brief   : Directed loopback bench for diff_io_prbs_loopback (4 ch, ERR_W=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_diff_io_prbs_loopback;

  localparam int CH = 4;
  localparam int EW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            oe = 1'b1;
  logic            clear = 1'b0;
  logic [CH-1:0]   inj_err = '0;
  logic [CH-1:0]   swap = '0;
  wire  [CH-1:0]   din_p, din_n;
  wire  [CH-1:0]   dout_p, dout_n;
  wire  [CH-1:0]   lock;
  wire  [CH*EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Board loopback; a set swap bit crosses that channel's RX pair
  assign din_p = (swap & dout_n) | (~swap & dout_p);
  assign din_n = (swap & dout_p) | (~swap & dout_n);

  diff_io_prbs_loopback #(
    .CHANNELS (CH),
    .ERR_W    (EW),
    .LOCK_CNT (16),
    .LOSS_CNT (4),
    .TX_INV   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .oe      (oe),
    .clear   (clear),
    .inj_err (inj_err),
    .din_p   (din_p),
    .din_n   (din_n),
    .dout_p  (dout_p),
    .dout_n  (dout_n),
    .lock    (lock),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_err(input string name, input logic [CH*EW-1:0] exp);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_err_ch%0d", name, c), 32'(err_cnt[c*EW +: EW]), 32'(exp[c*EW +: EW]));
  endtask

  typedef struct {
    logic [CH-1:0]    inj;
    int               reps;
    logic [CH-1:0]    swp;
    logic             clr;
    int               wait_cyc;
    logic [CH-1:0]    exp_lock;
    logic [CH*EW-1:0] exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{inj: 4'b0010, reps: 1, swp: 4'b0000, clr: 1'b0, wait_cyc: 20, exp_lock: 4'hF, exp_err: 16'h0030};
    vecs[1] = '{inj: 4'b0000, reps: 0, swp: 4'b0100, clr: 1'b0, wait_cyc: 30, exp_lock: 4'hB, exp_err: 16'h0430};
    vecs[2] = '{inj: 4'b0000, reps: 0, swp: 4'b0000, clr: 1'b0, wait_cyc: 50, exp_lock: 4'hF, exp_err: 16'h0430};
    vecs[3] = '{inj: 4'b0001, reps: 6, swp: 4'b0000, clr: 1'b0, wait_cyc: 20, exp_lock: 4'hF, exp_err: 16'h043F};
    vecs[4] = '{inj: 4'b0000, reps: 0, swp: 4'b0000, clr: 1'b1, wait_cyc: 5,  exp_lock: 4'hF, exp_err: 16'h0000};

    // Reset state
    run(3);
    check("rst_lock", 32'(lock), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    check("rst_dout_p", 32'(dout_p), 32'hF);
    check("rst_dout_n", 32'(dout_n), 32'h0);

    // Initial lock and long clean run
    rst = 1'b0;
    en  = 1'b1;
    run(27);
    check("lock_by_27", 32'(lock), 32'hF);
    run(1000);
    check("lock_1000", 32'(lock), 32'hF);
    check_all_err("clean_1000", '0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].clr) begin
        clear = 1'b1;
        run(1);
        clear = 1'b0;
      end
      swap = vecs[v].swp;
      for (int r = 0; r < vecs[v].reps; r++) begin
        inj_err = vecs[v].inj;
        run(1);
        inj_err = '0;
        run(9);
      end
      run(vecs[v].wait_cyc);
      check($sformatf("vec%0d_lock", v), 32'(lock), 32'(vecs[v].exp_lock));
      check_all_err($sformatf("vec%0d", v), vecs[v].exp_err);
    end

    // Clear coinciding with the third error increment of a single flip
    inj_err = 4'b1000;
    run(1);
    inj_err = '0;
    run(8);
    check("clr_inc_pre", 32'(err_cnt[3*EW +: EW]), 32'd2);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    check("clr_inc_same", 32'(err_cnt[3*EW +: EW]), 32'd0);
    run(5);
    check("clr_inc_after", 32'(err_cnt[3*EW +: EW]), 32'd0);
    check("clr_inc_lock", 32'(lock), 32'hF);

    // Pause: lock drops, counts hold, relock on resume
    inj_err = 4'b0010;
    run(1);
    inj_err = '0;
    run(15);
    check("pause_pre_err", 32'(err_cnt), 32'h0030);
    en = 1'b0;
    run(10);
    check("pause_lock", 32'(lock), 32'h0);
    check("pause_err", 32'(err_cnt), 32'h0030);
    en = 1'b1;
    run(40);
    check("resume_lock", 32'(lock), 32'hF);
    check("resume_err", 32'(err_cnt), 32'h0030);

    // Asynchronous reset between clock edges
    rst = 1'b1;
    #1;
    check("async_lock", 32'(lock), 32'h0);
    check("async_err", 32'(err_cnt), 32'h0);
    check("async_dout_p", 32'(dout_p), 32'hF);
    #1;
    rst = 1'b0;
    run(27);
    check("relock_by_27", 32'(lock), 32'hF);
    run(100);
    check_all_err("relock_clean", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
